// File: rtl/affine_transform_pipe_if.sv
// Beat-level handshake bundle for the S-box affine pipe: input beat, output beat, and the
// completed-beat counter.
interface affine_transform_pipe_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 in_encrypt;
    logic [LANES-1:0]     in_lane_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic                 out_encrypt;
    logic [CNT_W-1:0]     beat_count;

    modport slave (
        input  in_valid, in_data, in_encrypt, in_lane_en, out_ready,
        output in_ready, out_valid, out_data, out_encrypt, beat_count
    );

    modport master (
        output in_valid, in_data, in_encrypt, in_lane_en, out_ready,
        input  in_ready, out_valid, out_data, out_encrypt, beat_count
    );
endinterface

// File: rtl/affine_transform_pipe.sv
// Multi-lane elastic pipeline applying the AES S-box forward or inverse affine map per byte,
// with valid/ready flow control and a completed-beat counter.
module affine_lane (
    input  logic [7:0] b,
    input  logic       encrypt,
    input  logic       en,
    output logic [7:0] y
);
    logic [7:0] r1, r2, r3, r4, r6;

    assign r1 = {b[6:0], b[7]};
    assign r2 = {b[5:0], b[7:6]};
    assign r3 = {b[4:0], b[7:5]};
    assign r4 = {b[3:0], b[7:4]};
    assign r6 = {b[1:0], b[7:2]};

    // Gating happens after the constant so a disabled lane is a clean zero.
    always_comb begin
        y = '0;
        if (en) begin
            if (encrypt) y = b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
            else         y = r1 ^ r3 ^ r6 ^ 8'h05;
        end
    end
endmodule

module affine_transform_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   reset,
    affine_transform_pipe_if.slave bus
);
    localparam int S = PIPE_STAGES;

    logic [LANES-1:0][7:0]         in_bytes;
    logic [LANES-1:0][7:0]         xf;
    logic [S-1:0][LANES-1:0][7:0]  data_pipe;
    logic [S-1:0]                  enc_pipe;
    logic [S-1:0]                  vld_pipe;
    logic [S-1:0]                  ld;
    logic                          full;
    logic [CNT_W-1:0]              cnt;

    assign in_bytes = bus.in_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        affine_lane u_lane (
            .b       (in_bytes[l]),
            .encrypt (bus.in_encrypt),
            .en      (bus.in_lane_en[l]),
            .y       (xf[l])
        );
    end

    // Stage k may load when downstream drains or some stage at or after k is empty.
    always_comb begin
        ld   = '0;
        full = 1'b1;
        for (int k = S - 1; k >= 0; k--) begin
            full  = full & vld_pipe[k];
            ld[k] = bus.out_ready | ~full;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            enc_pipe  <= '0;
            cnt       <= '0;
        end else begin
            if (ld[0]) begin
                vld_pipe[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_pipe[0] <= xf;
                    enc_pipe[0]  <= bus.in_encrypt;
                end
            end
            // Payload moves only with a valid beat, so idle stages keep their last value.
            for (int k = 1; k < S; k++) begin
                if (ld[k]) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    if (vld_pipe[k-1]) begin
                        data_pipe[k] <= data_pipe[k-1];
                        enc_pipe[k]  <= enc_pipe[k-1];
                    end
                end
            end
            if (vld_pipe[S-1] && bus.out_ready) cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready    = ld[0];
    assign bus.out_valid   = vld_pipe[S-1];
    assign bus.out_data    = data_pipe[S-1];
    assign bus.out_encrypt = enc_pipe[S-1];
    assign bus.beat_count  = cnt;
endmodule

// File: tb/tb_affine_transform_pipe.sv
// Randomized and directed bench for affine_transform_pipe; a queue-based model predicts every
// output beat, its arrival cycle, the ready signal and the beat counter.
module tb_affine_transform_pipe;
    localparam int LANES = 4;
    localparam int S     = 3;
    localparam int CNT_W = 4;
    localparam int W     = 8 * LANES;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    affine_transform_pipe_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

    affine_transform_pipe #(.LANES(LANES), .PIPE_STAGES(S), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Straight from the bit equations: y[i] built from b[(i+k) mod 8] terms plus a constant.
    function automatic logic [7:0] aff(input logic [7:0] b, input logic enc);
        logic [7:0] c;
        logic [7:0] y;
        c = enc ? 8'h63 : 8'h05;
        for (int i = 0; i < 8; i++) begin
            if (enc) y[i] = b[i] ^ b[3'(i+4)] ^ b[3'(i+5)] ^ b[3'(i+6)] ^ b[3'(i+7)] ^ c[i];
            else     y[i] = b[3'(i+2)] ^ b[3'(i+5)] ^ b[3'(i+7)] ^ c[i];
        end
        return y;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic enc,
                                           input logic [LANES-1:0] en);
        logic [LANES-1:0][7:0] dv;
        logic [LANES-1:0][7:0] ov;
        dv = d;
        for (int l = 0; l < LANES; l++) ov[l] = en[l] ? aff(dv[l], enc) : 8'h00;
        return ov;
    endfunction

    typedef struct {
        logic [W-1:0] d;
        logic         e;
        int           rdy;
    } beat_s;

    beat_s            q[$];
    logic [CNT_W-1:0] cnt_m;

    always @(posedge clk) cyc <= cyc + 1;

    // The oldest beat is never blocked, so it must appear exactly at its nominal cycle.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            cnt_m = '0;
        end else begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0 && cyc >= q[0].rdy));
            if (bus.out_valid && q.size() > 0) begin
                chk("out_data", 64'(bus.out_data), 64'(q[0].d));
                chk("out_encrypt", 64'(bus.out_encrypt), 64'(q[0].e));
            end
            chk("in_ready", 64'(bus.in_ready), 64'(!(q.size() == S && !bus.out_ready)));
            chk("beat_count", 64'(bus.beat_count), 64'(cnt_m));
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                cnt_m++;
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{d: model(bus.in_data, bus.in_encrypt, bus.in_lane_en),
                              e: bus.in_encrypt, rdy: cyc + S});
        end
    end

    // Entered and left at posedge+1; holds the beat until it is accepted.
    task automatic send(input logic [W-1:0] d, input logic enc, input logic [LANES-1:0] en);
        int t;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_encrypt = enc;
        bus.in_lane_en = en;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 64'(1), 64'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        bus.out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while ((bus.out_valid || q.size() > 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("drain_timeout", 64'(1), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] d, input logic enc,
                            input logic [LANES-1:0] en, input logic [W-1:0] exp);
        int lat;
        bus.out_ready = 1'b1;
        send(d, enc, en);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'(S - 1));
        chk(tag, 64'(bus.out_data), 64'(exp));
        chk({tag, "_enc"}, 64'(bus.out_encrypt), 64'(enc));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int n);
        logic pend;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pend = bus.in_valid && !bus.in_ready;
            @(posedge clk);
            #1;
            if (!pend) begin
                bus.in_valid   = 1'($urandom_range(0, 1));
                bus.in_data    = W'($urandom);
                bus.in_encrypt = 1'($urandom_range(0, 1));
                bus.in_lane_en = LANES'($urandom_range(0, 15));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [CNT_W-1:0] b0;
        int c0;
        bit done;

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_encrypt = 1'b0;
        bus.in_lane_en = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_encrypt", 64'(bus.out_encrypt), 64'(0));
        chk("rst_beat_count", 64'(bus.beat_count), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        directed("fwd", 32'h0001_53FF, 1'b1, 4'hF, 32'h637C_749C);
        directed("inv", 32'h637C_749C, 1'b0, 4'hF, 32'h0001_53FF);
        directed("inv_zero", 32'h0000_0000, 1'b0, 4'hF, 32'h0505_0505);
        directed("gate", 32'h0101_0101, 1'b1, 4'b0101, 32'h007C_007C);
        directed("gate_inv", 32'h0000_0000, 1'b0, 4'b1010, 32'h0500_0500);

        // Ten beats against a coin-flip out_ready.
        b0   = bus.beat_count;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(W'($urandom), 1'($urandom_range(0, 1)), 4'hF);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        chk("bp_count", 64'(bus.beat_count), 64'(CNT_W'(b0 + CNT_W'(10))));

        // Alternating modes back to back at full rate.
        bus.out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 12; i++) send(W'($urandom), 1'(i % 2), 4'hF);
        chk("full_rate_cycles", 64'(cyc - c0), 64'(12));
        drain();

        rand_run(300);
        drain();

        // Two beats stuck in flight, then an asynchronous reset.
        bus.out_ready = 1'b0;
        send(32'hDEAD_BEEF, 1'b1, 4'hF);
        send(32'h1234_5678, 1'b0, 4'hF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'(0));
        chk("async_beat_count", 64'(bus.beat_count), 64'(0));
        chk("async_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        directed("post_rst", 32'hFF00_FF00, 1'b1, 4'hF, 32'h9C63_9C63);

        // Fifteen more beats take the 4-bit counter from 1 through 15 and back to 0.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(W'($urandom), 1'($urandom_range(0, 1)), 4'hF);
        drain();
        chk("wrap", 64'(bus.beat_count), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
